// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed hexadecimal 7-segment display driver.
// Digits are lit one at a time through shared, active-low segment lines.
// A dark gap between digits prevents ghosting.
// Optional feature macro: LEADING_ZERO_BLANK_EN. When it is defined, digits
// above the most significant nonzero nibble are darkened. Digit 0 is never
// darkened by this feature.
module hex_scan_display #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000,
    parameter int GAP_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   blank_mask,
    input  logic                load,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);

    localparam int TMAX  = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NSLOT = 1 << IW;

    localparam logic [TW-1:0] SHOW_LAST = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t              r_state;
    logic [TW-1:0]       r_timer;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_mask;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_done;

    // The nibble and dark flags are padded to a power-of-two table.
    // Padding slots are dark and never selected.
    logic [3:0]          w_nib  [NSLOT];
    logic [NSLOT-1:0]    w_dark;
    logic [DIGITS-1:0]   w_auto;
    logic [IW-1:0]       w_idx_inc;
    logic [IW-1:0]       w_entry_idx;
    logic                w_entry_dark;
    logic [6:0]          w_entry_seg;
    logic [DIGITS-1:0]   w_entry_an;

    // Active-low g..a pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'b1000000;
            4'h1: code = 7'b1111001;
            4'h2: code = 7'b0100100;
            4'h3: code = 7'b0110000;
            4'h4: code = 7'b0011001;
            4'h5: code = 7'b0010010;
            4'h6: code = 7'b0000010;
            4'h7: code = 7'b1111000;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0011000;
            4'hA: code = 7'b0001000;
            4'hB: code = 7'b0000011;
            4'hC: code = 7'b1000110;
            4'hD: code = 7'b0100001;
            4'hE: code = 7'b0000110;
            default: code = 7'b0001110;
        endcase
        return code;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is auto-darkened when it and every digit above it are zero.
    // Digit 0 is exempt so that a zero value still shows "0".
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
            if (gi == 0) begin : g_first
                assign w_auto[gi] = 1'b0;
            end else begin : g_upper
                assign w_auto[gi] = (r_value[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate
`else
    assign w_auto = '0;
`endif

    // Build the per-slot nibble and dark tables from the shadow registers.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < DIGITS) begin : g_real
                assign w_nib[gi]  = r_value[4*gi +: 4];
                assign w_dark[gi] = r_mask[gi] | w_auto[gi];
            end else begin : g_pad
                assign w_nib[gi]  = 4'h0;
                assign w_dark[gi] = 1'b1;
            end
        end
    endgenerate

    // Compute the digit index that the next SHOW entry displays, and that digit's segment pattern.
    always_comb begin
        w_idx_inc    = (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
        // In SHOW, an entry only happens back-to-back (no gap), so it is for the following digit.
        w_entry_idx  = (r_state == ST_SHOW) ? w_idx_inc : r_idx;
        w_entry_dark = w_dark[w_entry_idx];
        w_entry_seg  = w_entry_dark ? 7'h7F : hex_to_seg(w_nib[w_entry_idx]);
    end

    // Build the digit-enable word for the entry: exactly one bit low, or all high when the digit is dark.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
            assign w_entry_an[gi] = w_entry_dark | (w_entry_idx != IW'(gi));
        end
    endgenerate

    // Scan FSM: shadow capture, GAP/SHOW timing, and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_GAP;
            r_timer      <= '0;
            r_idx        <= '0;
            r_value      <= '0;
            r_mask       <= '0;
            r_seg        <= 7'h7F;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            if (load) begin
                r_value <= value;
                r_mask  <= blank_mask;
            end
            r_frame_done <= 1'b0;
            case (r_state)
                ST_GAP: begin
                    if ((GAP_CYC == 0) || (r_timer == GAP_LAST)) begin
                        r_state <= ST_SHOW;
                        r_timer <= '0;
                        r_seg   <= w_entry_seg;
                        r_an    <= w_entry_an;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    if (r_timer == SHOW_LAST) begin
                        r_idx        <= w_idx_inc;
                        r_timer      <= '0;
                        r_frame_done <= (r_idx == LAST_IDX);
                        if (GAP_CYC == 0) begin
                            r_state <= ST_SHOW;
                            r_seg   <= w_entry_seg;
                            r_an    <= w_entry_an;
                        end else begin
                            r_state <= ST_GAP;
                            r_seg   <= 7'h7F;
                            r_an    <= '1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
            endcase
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hex_scan_display.sv
// Testbench for hex_scan_display (DIGITS=4, CLK_DIV=4, GAP_CYC=2).
// The reference model derives the scan position from the edge count since reset.
// Each SHOW entry latches the shadow value that was held just before that edge.
module tb_hex_scan_display;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;
    localparam int GAP_CYC = 2;
    localparam int PER     = CLK_DIV + GAP_CYC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    hex_scan_display #(
        .DIGITS (DIGITS),
        .CLK_DIV(CLK_DIV),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .blank_mask(blank_mask),
        .load      (load),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [6:0]  seg_tbl [16];
    int          m_n = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_mask = '0;
    logic [6:0]  exp_seg = 7'h7F;
    logic [3:0]  exp_an = 4'hF;
    logic        exp_fd = 1'b0;

    function automatic bit model_auto_dark(input logic [15:0] v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b0;
        return ((v >> (4 * d)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    // Advance one clock edge and update the model from the inputs sampled at that edge.
    task automatic tick();
        logic [15:0] v_before;
        logic [3:0]  m_before;
        int          k;
        int          r;
        int          d;
        bit          dark;
        @(posedge clk);
        if (rst) begin
            m_n = 0; m_val = '0; m_mask = '0;
            exp_seg = 7'h7F; exp_an = 4'hF; exp_fd = 1'b0;
        end else begin
            v_before = m_val;
            m_before = m_mask;
            if (load) begin
                m_val  = value;
                m_mask = blank_mask;
            end
            m_n++;
            k = m_n / PER;
            r = m_n % PER;
            exp_fd = (r == 0) && ((k % DIGITS) == 0);
            if (r < GAP_CYC) begin
                exp_seg = 7'h7F; exp_an = 4'hF;
            end else if (r == GAP_CYC) begin
                d = k % DIGITS;
                dark = m_before[d] || model_auto_dark(v_before, d);
                if (dark) begin
                    exp_seg = 7'h7F; exp_an = 4'hF;
                end else begin
                    exp_an  = 4'hF & ~(4'b0001 << d);
                    exp_seg = seg_tbl[v_before[4*d +: 4]];
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({seg, an, frame_done} !== {7'h7F, 4'hF, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold: got seg=%b an=%b fd=%b, expected seg=1111111 an=1111 fd=0", seg, an, frame_done);
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({seg, an} !== {7'h7F, 4'hF}) begin
            n_fail++;
            $display("FAIL reset_gap: got seg=%b an=%b, expected seg=1111111 an=1111", seg, an);
        end
        tick();
        n_checks++;
        if ({seg, an} !== {7'b1000000, 4'b1110}) begin
            n_fail++;
            $display("FAIL reset_first_digit: got seg=%b an=%b, expected seg=1000000 an=1110", seg, an);
        end
        $display("test_reset: first digit entered at edge %0d after release", m_n);
    endtask

    task automatic test_scan();
        int fd_count = 0;
        value = 16'h1A2F; blank_mask = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4 * PER * 2; i++) begin
            tick();
            if (frame_done === 1'b1) fd_count++;
            n_checks++;
            if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_fail++;
                $display("FAIL scan n=%0d: got seg=%b an=%b fd=%b, expected seg=%b an=%b fd=%b",
                         m_n, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
        n_checks++;
        if (fd_count != 2) begin
            n_fail++;
            $display("FAIL scan_frame_done_count: got %0d pulses in 48 cycles, expected 2", fd_count);
        end
        $display("test_scan: value=1a2f frame_done pulses=%0d", fd_count);
    endtask

    task automatic test_mask();
        value = 16'h8888; blank_mask = 4'b0101; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n_checks++;
            if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_fail++;
                $display("FAIL mask n=%0d: got seg=%b an=%b fd=%b, expected seg=%b an=%b fd=%b",
                         m_n, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
        $display("test_mask: value=8888 mask=0101 checked 30 cycles");
    endtask

    task automatic test_load_mid_digit();
        bit found = 1'b0;
        value = 16'h1A2F; blank_mask = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (PER) tick();
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if ((m_n % PER == GAP_CYC + 1) && ((m_n / PER) % DIGITS == 0)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL load_mid_sync: digit 0 second SHOW cycle not reached within 200 cycles");
        end
        value = 16'h0005; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < PER && (m_n % PER) >= GAP_CYC; i++) begin
            n_checks++;
            if ({seg, an} !== {7'b0001110, 4'b1110}) begin
                n_fail++;
                $display("FAIL load_mid_hold n=%0d: got seg=%b an=%b, expected seg=0001110 an=1110", m_n, seg, an);
            end
            tick();
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            n_checks++;
            if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_fail++;
                $display("FAIL load_mid n=%0d: got seg=%b an=%b fd=%b, expected seg=%b an=%b fd=%b",
                         m_n, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            tick();
            if ((m_n % PER == GAP_CYC) && ((m_n / PER) % DIGITS == 0)) found = 1'b1;
        end
        n_checks++;
        if (!found || ({seg, an} !== {7'b0010010, 4'b1110})) begin
            n_fail++;
            $display("FAIL load_mid_new: got seg=%b an=%b, expected seg=0010010 an=1110", seg, an);
        end
        $display("test_load_mid_digit: 0005 shown on next digit 0 entry at edge %0d", m_n);
    endtask

    task automatic test_reset_mid_frame();
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (((m_n / PER) % DIGITS == 2) && ((m_n % PER) >= GAP_CYC + 1)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_sync: digit 2 not reached within 200 cycles");
        end
        rst = 1'b1; load = 1'b1; value = 16'hFFFF; blank_mask = 4'hF;
        tick();
        rst = 1'b0; load = 1'b0;
        n_checks++;
        if ({seg, an, frame_done} !== {7'h7F, 4'hF, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_dark: got seg=%b an=%b fd=%b, expected seg=1111111 an=1111 fd=0", seg, an, frame_done);
        end
        tick();
        tick();
        n_checks++;
        if ({seg, an} !== {7'b1000000, 4'b1110}) begin
            n_fail++;
            $display("FAIL rst_mid_restart: got seg=%b an=%b, expected seg=1000000 an=1110", seg, an);
        end
        for (int i = 0; i < 24; i++) begin
            tick();
            n_checks++;
            if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_fail++;
                $display("FAIL rst_mid n=%0d: got seg=%b an=%b fd=%b, expected seg=%b an=%b fd=%b",
                         m_n, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
        $display("test_reset_mid_frame: reset with simultaneous load, scan restarted at digit 0");
    endtask

    task automatic test_leading_zero();
        logic [15:0] vals [2];
        bit          found;
        vals[0] = 16'h0030;
        vals[1] = 16'h0000;
        for (int t = 0; t < 2; t++) begin
            value = vals[t]; blank_mask = 4'b0000; load = 1'b1;
            tick();
            load = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 4 * PER * 2; i++) begin
                tick();
                n_checks++;
                if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                    n_fail++;
                    $display("FAIL lzb v=%h n=%0d: got seg=%b an=%b fd=%b, expected seg=%b an=%b fd=%b",
                             vals[t], m_n, seg, an, frame_done, exp_seg, exp_an, exp_fd);
                end
                if (i >= PER && !found && (m_n % PER == GAP_CYC) && ((m_n / PER) % DIGITS == 3)) begin
                    found = 1'b1;
                    n_checks++;
`ifdef LEADING_ZERO_BLANK_EN
                    if ({seg, an} !== {7'h7F, 4'hF}) begin
`else
                    if ({seg, an} !== {7'b1000000, 4'b0111}) begin
`endif
                        n_fail++;
                        $display("FAIL lzb_digit3 v=%h: got seg=%b an=%b", vals[t], seg, an);
                    end
                end
            end
            n_checks++;
            if (!found) begin
                n_fail++;
                $display("FAIL lzb_sync v=%h: digit 3 entry not observed", vals[t]);
            end
            $display("test_leading_zero: value=%h checked two frames", vals[t]);
        end
    endtask

    task automatic test_random();
        int          errs0;
        int          sh;
        logic [15:0] v16;
        errs0 = n_fail;
        for (int i = 0; i < 600; i++) begin
            v16 = 16'($urandom);
            sh = $urandom_range(0, 4);
            value = v16 >> (4 * sh);
            blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            load = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 249) == 0);
            tick();
            n_checks++;
            if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_fail++;
                $display("FAIL random n=%0d: got seg=%b an=%b fd=%b, expected seg=%b an=%b fd=%b",
                         m_n, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
        rst = 1'b0; load = 1'b0;
        $display("test_random: 600 cycles, %0d new discrepancies", n_fail - errs0);
    endtask

    initial begin
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        test_reset();
        test_scan();
        test_mask();
        test_load_mid_digit();
        test_reset_mid_frame();
        test_leading_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
